// File: rtl/rbi_l2_mmio_bridge.sv
// ---------------------------------------------------------------------------
// rbi_l2_mmio_bridge
//
// Last node of an L2 ring segment. It takes MMIO load/store requests off the
// ring, runs them one at a time on a simple 64-bit MMIO bus, and puts the
// response back on the ring. All other ring traffic passes through one
// register stage unchanged.
//
// Optional feature macro: RBI_MMIO_TIMEOUT_EN
//   defined   -> a 12-bit counter runs while a bus op is outstanding. After
//                4095 cycles with neither done nor fault, the op is failed
//                with code 64'hF00D.
//   undefined -> an outstanding bus op waits indefinitely.
//
// Ports
//   clock, reset            system clock; asynchronous active-low reset
//   memAddrIn/Out   [47:0]  ring slot address
//   memDataIn/Out  [127:0]  ring slot data
//   memOpmIn/Out    [15:0]  ring slot op mode; [7:0]==0 marks an empty slot
//   memSeqIn/Out    [15:0]  ring sequence: [15:8] source node, [7:0] tag
//   unitNodeId       [7:0]  this node's ID (informational only)
//   mmioAddr        [31:0]  MMIO bus address (holds its last value when idle)
//   mmioOpm          [4:0]  bus op: [3] read, [4] write, [1:0] size; 0 = idle
//   mmioOutData     [63:0]  store data (holds its last value when idle)
//   mmioInData      [63:0]  load data from the bus
//   mmioOK           [1:0]  bus status: 00 idle, 01 done, 10 busy, 11 fault
//   mmioExcIn       [63:0]  fault code, valid while mmioOK==11
//   dbgState         [1:0]  current FSM state, for observation
//
// Bus handshake: the bridge holds a nonzero mmioOpm while a request is
// outstanding. The bus answers with mmioOK==10 (busy) for any number of
// cycles, then 01 (done) or 11 (fault). The bridge drops mmioOpm to 0 on
// the edge that samples done/fault. The bus must then return mmioOK to 00
// before the bridge will consider the op closed. Only after that is the
// response offered to the ring.
// ---------------------------------------------------------------------------
module rbi_l2_mmio_bridge (
  input  logic         clock,
  input  logic         reset,
  input  logic [47:0]  memAddrIn,
  input  logic [127:0] memDataIn,
  input  logic [15:0]  memOpmIn,
  input  logic [15:0]  memSeqIn,
  output logic [47:0]  memAddrOut,
  output logic [127:0] memDataOut,
  output logic [15:0]  memOpmOut,
  output logic [15:0]  memSeqOut,
  input  logic [7:0]   unitNodeId,
  output logic [31:0]  mmioAddr,
  output logic [4:0]   mmioOpm,
  output logic [63:0]  mmioOutData,
  input  logic [63:0]  mmioInData,
  input  logic [1:0]   mmioOK,
  input  logic [63:0]  mmioExcIn,
  output logic [1:0]   dbgState
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRelease = 2'd2,
    StResp    = 2'd3
  } state_t;

  localparam logic [1:0] OkIdle  = 2'b00;
  localparam logic [1:0] OkDone  = 2'b01;
  localparam logic [1:0] OkFault = 2'b11;

  state_t       state, stateNext;

  // Request context kept for the response.
  logic [15:0]  reqSeq, reqSeqNext;
  logic [47:0]  reqAddr, reqAddrNext;
  logic [1:0]   reqSize, reqSizeNext;
  logic         reqStore, reqStoreNext;
  logic [63:0]  respData, respDataNext;
  logic         respFault, respFaultNext;

  // Registered outputs.
  logic [47:0]  memAddrNext;
  logic [127:0] memDataNext;
  logic [15:0]  memOpmNext;
  logic [15:0]  memSeqNext;
  logic [31:0]  mmioAddrNext;
  logic [4:0]   mmioOpmNext;
  logic [63:0]  mmioOutDataNext;

`ifdef RBI_MMIO_TIMEOUT_EN
  // The counter holds (cycles spent in ISSUE - 1) at each sampling edge. So
  // matching 4094 means this edge is the 4095th one without an answer.
  localparam logic [11:0] TimeoutLast = 12'd4094;
  logic [11:0]  toCnt, toCntNext;
`endif

  // The node ID is informational only; nothing depends on it.
  logic unusedInputs;
  assign unusedInputs = ^unitNodeId;

  // Request classification.
  logic        inLoad, inStore, inWindow, inReq, inEmpty;
  logic [15:0] respOpm;

  assign inLoad   = (memOpmIn[7:2] == 6'b1001_00);  // 0x90..0x93
  assign inStore  = (memOpmIn[7:2] == 6'b1010_00);  // 0xA0..0xA3
  assign inWindow = (memAddrIn[31:28] == 4'hF);
  assign inReq    = (inLoad || inStore) && inWindow;
  assign inEmpty  = (memOpmIn[7:0] == 8'h00);

  // A fault overrides the op type. A store-done never carries data because
  // respData is cleared for stores when done is sampled.
  always_comb begin
    respOpm = 16'h0000;
    if (respFault) begin
      respOpm = 16'h0070;
    end else if (reqStore) begin
      respOpm = 16'h0060;
    end else begin
      respOpm = {14'h0014, reqSize};  // 0x50 | size
    end
  end

  assign dbgState = state;

  // Next-state and next-output logic.
  always_comb begin
    stateNext       = state;
    reqSeqNext      = reqSeq;
    reqAddrNext     = reqAddr;
    reqSizeNext     = reqSize;
    reqStoreNext    = reqStore;
    respDataNext    = respData;
    respFaultNext   = respFault;
    memAddrNext     = memAddrIn;
    memDataNext     = memDataIn;
    memOpmNext      = memOpmIn;
    memSeqNext      = memSeqIn;
    mmioAddrNext    = mmioAddr;
    mmioOpmNext     = 5'd0;
    mmioOutDataNext = mmioOutData;
`ifdef RBI_MMIO_TIMEOUT_EN
    toCntNext       = 12'd0;
`endif

    case (state)
      StIdle: begin
        if (inReq) begin
          reqSeqNext      = memSeqIn;
          reqAddrNext     = memAddrIn;
          reqSizeNext     = memOpmIn[1:0];
          reqStoreNext    = inStore;
          respDataNext    = 64'd0;
          respFaultNext   = 1'b0;
          // The request is absorbed, so its slot leaves the node empty.
          memAddrNext     = 48'd0;
          memDataNext     = 128'd0;
          memOpmNext      = 16'd0;
          memSeqNext      = 16'd0;
          mmioAddrNext    = memAddrIn[31:0];
          mmioOpmNext     = {inStore, inLoad, 1'b0, memOpmIn[1:0]};
          mmioOutDataNext = memDataIn[63:0];
          stateNext       = StIssue;
        end
      end

      StIssue: begin
        mmioOpmNext = mmioOpm;
`ifdef RBI_MMIO_TIMEOUT_EN
        toCntNext   = toCnt + 12'd1;
`endif
        if (mmioOK == OkDone) begin
          respDataNext  = reqStore ? 64'd0 : mmioInData;
          respFaultNext = 1'b0;
          mmioOpmNext   = 5'd0;
          stateNext     = StRelease;
        end else if (mmioOK == OkFault) begin
          respDataNext  = mmioExcIn;
          respFaultNext = 1'b1;
          mmioOpmNext   = 5'd0;
          stateNext     = StRelease;
        end
`ifdef RBI_MMIO_TIMEOUT_EN
        else if (toCnt == TimeoutLast) begin
          respDataNext  = 64'h0000_0000_0000_F00D;
          respFaultNext = 1'b1;
          mmioOpmNext   = 5'd0;
          stateNext     = StRelease;
        end
`endif
      end

      StRelease: begin
        if (mmioOK == OkIdle) begin
          stateNext = StResp;
        end
      end

      StResp: begin
        // The response can only take a free slot; occupied slots pass on.
        if (inEmpty) begin
          memAddrNext = reqAddr;
          memDataNext = {64'd0, respData};
          memOpmNext  = respOpm;
          memSeqNext  = reqSeq;
          stateNext   = StIdle;
        end
      end

      default: begin
        stateNext = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      reqSeq      <= 16'd0;
      reqAddr     <= 48'd0;
      reqSize     <= 2'd0;
      reqStore    <= 1'b0;
      respData    <= 64'd0;
      respFault   <= 1'b0;
      memAddrOut  <= 48'd0;
      memDataOut  <= 128'd0;
      memOpmOut   <= 16'd0;
      memSeqOut   <= 16'd0;
      mmioAddr    <= 32'd0;
      mmioOpm     <= 5'd0;
      mmioOutData <= 64'd0;
`ifdef RBI_MMIO_TIMEOUT_EN
      toCnt       <= 12'd0;
`endif
    end else begin
      state       <= stateNext;
      reqSeq      <= reqSeqNext;
      reqAddr     <= reqAddrNext;
      reqSize     <= reqSizeNext;
      reqStore    <= reqStoreNext;
      respData    <= respDataNext;
      respFault   <= respFaultNext;
      memAddrOut  <= memAddrNext;
      memDataOut  <= memDataNext;
      memOpmOut   <= memOpmNext;
      memSeqOut   <= memSeqNext;
      mmioAddr    <= mmioAddrNext;
      mmioOpm     <= mmioOpmNext;
      mmioOutData <= mmioOutDataNext;
`ifdef RBI_MMIO_TIMEOUT_EN
      toCnt       <= toCntNext;
`endif
    end
  end

endmodule

// File: tb/tb_rbi_l2_mmio_bridge.sv
// ---------------------------------------------------------------------------
// tb_rbi_l2_mmio_bridge
//
// Bench for rbi_l2_mmio_bridge. Each cycle it drives one ring slot and plays
// the MMIO bus. The expected ring output is built from a transaction
// timeline:
//   - a request is accepted on edge A;
//   - the bus is busy for B cycles;
//   - it answers on edge D = A+B+1 and holds the answer H extra cycles;
//   - it returns to idle on edge R = D+H+1;
//   - the response takes the first empty input slot on an edge after R.
// Expected slots go through exp_q.
// ---------------------------------------------------------------------------
module tb_rbi_l2_mmio_bridge;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [47:0]  memAddrIn = '0;
  logic [127:0] memDataIn = '0;
  logic [15:0]  memOpmIn = '0;
  logic [15:0]  memSeqIn = '0;
  logic [47:0]  memAddrOut;
  logic [127:0] memDataOut;
  logic [15:0]  memOpmOut;
  logic [15:0]  memSeqOut;
  logic [31:0]  mmioAddr;
  logic [4:0]   mmioOpm;
  logic [63:0]  mmioOutData;
  logic [63:0]  mmioInData = '0;
  logic [1:0]   mmioOK = 2'b00;
  logic [63:0]  mmioExcIn = '0;
  logic [1:0]   dbgState;

  rbi_l2_mmio_bridge dut (
    .clock(clock), .reset(reset),
    .memAddrIn(memAddrIn), .memDataIn(memDataIn), .memOpmIn(memOpmIn), .memSeqIn(memSeqIn),
    .memAddrOut(memAddrOut), .memDataOut(memDataOut), .memOpmOut(memOpmOut), .memSeqOut(memSeqOut),
    .unitNodeId(8'h86),
    .mmioAddr(mmioAddr), .mmioOpm(mmioOpm), .mmioOutData(mmioOutData),
    .mmioInData(mmioInData), .mmioOK(mmioOK), .mmioExcIn(mmioExcIn),
    .dbgState(dbgState)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [207:0] exp_q[$];

  task automatic chk(input string tag, input logic [207:0] obs, input logic [207:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int          cyc = 0;
  bit          busy = 0;
  int          acceptE, doneE, relE;
  bit          fault, rStore;
  logic [1:0]  rSize;
  logic [15:0] rSeq;
  logic [47:0] rAddr;
  logic [63:0] rData;
  logic [4:0]  busOp;
  logic [31:0] expMmioAddr = '0;
  logic [63:0] expMmioOutData = '0;

  // Bus behaviour for the next accepted request.
  int          planB = 0, planHold = 0;
  bit          planFault = 0, randPlan = 0, useFixed = 0, silent = 0;
  logic [63:0] planData = '0, planExc = '0;

  function automatic logic [207:0] mkSlot(input logic [47:0] a, input logic [127:0] d,
                                          input logic [15:0] o, input logic [15:0] s);
    return {a, d, o, s};
  endfunction

  function automatic logic [207:0] rndEmpty();
    logic [15:0] o;
    o = {8'($urandom_range(0, 255)), 8'h00};
    return mkSlot({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, o, 16'($urandom));
  endfunction

  function automatic logic [1:0] busOk(input int e);
    if (!busy || silent) return 2'b00;
    if (e < doneE) return 2'b10;
    if (e < relE) return fault ? 2'b11 : 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver: one ring cycle ----------------
  task automatic step(input logic [207:0] slot);
    int           e;
    logic [1:0]   ok;
    logic [63:0]  inD, exc;
    logic [47:0]  a;
    logic [127:0] d;
    logic [15:0]  o, s;
    logic [207:0] expSlot;
    logic [4:0]   expOpm;
    bit           isLd, isSt;
    e = cyc + 1;
    ok = busOk(e);
    inD = useFixed ? planData : {$urandom, $urandom};
    exc = useFixed ? planExc : {$urandom, $urandom};
    {a, d, o, s} = slot;
    memAddrIn = a; memDataIn = d; memOpmIn = o; memSeqIn = s;
    mmioOK = ok; mmioInData = inD; mmioExcIn = exc;

    expSlot = slot;
    isLd = (o[7:0] >= 8'h90) && (o[7:0] <= 8'h93);
    isSt = (o[7:0] >= 8'hA0) && (o[7:0] <= 8'hA3);
    if (!busy) begin
      if ((isLd || isSt) && a[31:28] == 4'hF) begin
        busy = 1; acceptE = e;
        rSeq = s; rAddr = a; rStore = isSt; rSize = o[1:0];
        busOp = {isSt, isLd, 1'b0, o[1:0]};
        expMmioAddr = a[31:0];
        expMmioOutData = d[63:0];
        expSlot = '0;
        if (randPlan) begin
          planB = $urandom_range(0, 4);
          planHold = $urandom_range(0, 2);
          planFault = ($urandom_range(0, 3) == 0);
        end
        if (silent) begin
          fault = 1; doneE = e + 4095; relE = doneE + 1;
        end else begin
          fault = planFault; doneE = e + planB + 1; relE = doneE + planHold + 1;
        end
      end
    end else begin
      if (e == doneE) rData = silent ? 64'hF00D : (fault ? exc : (rStore ? 64'd0 : inD));
      if (e > relE && o[7:0] == 8'h00) begin
        expSlot = mkSlot(rAddr, {64'd0, rData},
                         fault ? 16'h0070 : (rStore ? 16'h0060 : (16'h0050 | 16'(rSize))), rSeq);
        busy = 0;
      end
    end
    expOpm = (busy && e < doneE) ? busOp : 5'd0;
    exp_q.push_back(expSlot);

    @(posedge clock);
    #1;
    cyc++;
    chk("ring_slot", {memAddrOut, memDataOut, memOpmOut, memSeqOut}, exp_q.pop_front());
    chk("mmio_opm", 208'(mmioOpm), 208'(expOpm));
    chk("mmio_addr", 208'(mmioAddr), 208'(expMmioAddr));
    chk("mmio_out_data", 208'(mmioOutData), 208'(expMmioOutData));
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      step(rndEmpty());
      n++;
    end
  endtask

  function automatic logic [207:0] rndSlot();
    int          k;
    logic [47:0] a;
    logic [15:0] o;
    k = $urandom_range(0, 9);
    a = {$urandom, $urandom};
    o = 16'($urandom);
    if (k <= 3) return rndEmpty();
    if (k == 6 || k == 7 || k == 8) begin
      o[7:0] = {($urandom_range(0, 1) == 1) ? 4'hA : 4'h9, 2'b00, 2'($urandom_range(0, 3))};
      a[31:28] = (k == 8) ? 4'($urandom_range(0, 14)) : 4'hF;
    end else if (o[7:0] == 8'h00) begin
      o[7:0] = 8'h11;
    end
    return mkSlot(a, {$urandom, $urandom, $urandom, $urandom}, o, 16'($urandom));
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    // Asynchronous reset before any clock edge.
    #2;
    chk("reset_outputs", {memAddrOut, memDataOut, memOpmOut, memSeqOut},  208'd0);
    chk("reset_mmio", 208'({mmioAddr, mmioOpm, mmioOutData}), 208'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Pass-through.
    step(mkSlot(48'h1000, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 16'h0011, 16'h0A05));

    // Load with three busy cycles.
    useFixed = 1; planData = 64'h1122_3344_5566_7788; planExc = 64'h0;
    planB = 3; planHold = 0; planFault = 0;
    step(mkSlot(48'h0000_F000_0010, 128'h0, 16'h0093, 16'h0B07));
    drain(30);

    // Store with a zero-wait bus.
    planB = 0; planHold = 1;
    step(mkSlot(48'h0000_F000_0020, 128'hDEAD_BEEF, 16'h00A2, 16'h0C01));
    drain(30);

    // Fault.
    planFault = 1; planExc = 64'h8003; planB = 1; planHold = 0;
    step(mkSlot(48'h0000_F000_0030, 128'h0, 16'h0091, 16'h0D02));
    drain(30);

    // Contention: more requests in ISSUE, occupied slots during RESP.
    planFault = 0; planB = 2; planHold = 1; useFixed = 0;
    step(mkSlot(48'h0000_F000_0040, 128'h0, 16'h0092, 16'h0E03));
    step(mkSlot(48'h0000_F000_0050, 128'h55, 16'h00A3, 16'h0E04));
    for (int i = 0; i < 8; i++)
      step(mkSlot(48'h0000_F000_0060 + 48'(i), 128'(i), 16'h0090 + 16'(i % 4), 16'h0F00 + 16'(i)));
    drain(30);

    // Asynchronous reset while a bus op is outstanding.
    planB = 10;
    step(mkSlot(48'h0000_F000_0070, 128'h0, 16'h0093, 16'h0A0A));
    step(rndEmpty());
    reset = 1'b0;
    #1;
    chk("midreset_ring", {memAddrOut, memDataOut, memOpmOut, memSeqOut}, 208'd0);
    chk("midreset_mmio", 208'({mmioAddr, mmioOpm, mmioOutData}), 208'd0);
    busy = 0; expMmioAddr = '0; expMmioOutData = '0;
    mmioOK = 2'b00;
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b1;

`ifdef RBI_MMIO_TIMEOUT_EN
    // Silent bus: the op must time out with the F00D code.
    silent = 1;
    step(mkSlot(48'h0000_F000_0080, 128'h0, 16'h0090, 16'h0B0B));
    drain(4200);
    silent = 0;
`endif

    // Randomized traffic.
    randPlan = 1;
    for (int i = 0; i < 1500; i++) step(rndSlot());
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rbi_l2_mmio_bridge.md
# rbi_l2_mmio_bridge

Ring-bus node that bridges memory-mapped I/O requests on the L2 ring to a simple 64-bit MMIO bus. Sits last in the L2 ring segment (after the DRAM cache and ROM nodes); absorbs MMIO load/store requests, runs one bus transaction at a time, and re-injects the response into the ring. All other traffic passes through with one cycle of register latency.

## Interface
- No parameters.
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- memAddrIn / memAddrOut  in/out  48  ring slot address
- memDataIn / memDataOut  in/out  128  ring slot data (tile)
- memOpmIn / memOpmOut  in/out  16  ring slot op mode; [7:0]==0 means empty slot
- memSeqIn / memSeqOut  in/out  16  ring sequence; [15:8] source node, [7:0] tag
- unitNodeId  in  8  this node's ID (0x86 in the standard L2 ring); informational
- mmioAddr  out  32  MMIO bus address
- mmioOpm  out  5  bus op: [3] read, [4] write, [1:0] size (0=8b, 1=16b, 2=32b, 3=64b), [2]=0; 0 = idle
- mmioOutData  out  64  store data
- mmioInData  in  64  load data
- mmioOK  in  2  00 ready/idle, 01 done, 10 busy, 11 fault
- mmioExcIn  in  64  fault/exception code, valid with mmioOK==11

## Operation
- Request classification on memOpmIn[7:0]: 0x90–0x93 = MMIO load (size = [1:0]); 0xA0–0xA3 = MMIO store; only accepted when memAddrIn[31:28]==4'hF.
- Response op codes: 0x50|size load done, 0x60 store done, 0x70 fault. Responses keep Seq and Addr of the request; ring routes by Seq[15:8].
- States: IDLE, ISSUE, RELEASE, RESP.
- IDLE: matching request on input -> latch seq/opm/addr/data, output slot emptied (all out fields 0), go ISSUE. Anything else forwarded unchanged.
- ISSUE: mmioAddr=addr[31:0], mmioOpm from request, mmioOutData=data[63:0]. On OK==01: capture mmioInData (load) and go RELEASE. On OK==11: capture mmioExcIn, mark fault, go RELEASE. OK==10/00: stay.
- RELEASE: mmioOpm=0; on OK==00 go RESP.
- RESP: when input slot empty (memOpmIn[7:0]==0) output the response, go IDLE; otherwise forward input unchanged and keep waiting.
- Response data: [63:0]=load data or exception code; [127:64]=0; store-done data = 0.
- While not IDLE, further MMIO requests are forwarded unchanged (they recirculate and retry).
- mmioAddr/mmioOutData hold last values when idle; mmioOpm is 0 whenever not in ISSUE.

## Timing
- Reset (reset==0, asynchronous): all outputs 0, state IDLE, fault flag cleared; mid-transaction reset abandons the bus op immediately (mmioOpm=0).
- Pass-through latency exactly 1 cycle; every ring output is a register.
- Request sampled at edge N -> mmioOpm valid after edge N; empty slot on output after edge N.
- Done/fault sampled at edge M -> mmioOpm=0 after M; OK==00 sampled at edge K -> RESP after K; response emitted after the first later edge with empty input slot (earliest K+1).
- Minimum request-to-response: 4 cycles with a zero-wait bus.

## Configuration
- RBI_MMIO_TIMEOUT_EN: defined -> 12-bit counter runs in ISSUE; reaching 4095 cycles without OK==01/11 forces fault with code 64'h0000_0000_0000_F00D, then RELEASE. Undefined -> ISSUE waits indefinitely; no counter.

## Test plan
- Pass-through: opm 0x0011, addr 0x1000, seq 0x0A05 -> identical slot on outputs one cycle later, mmioOpm stays 0.
- Load: opm 0x0093, addr 0xF000_0010; bus returns OK=01 with 0x1122_3344_5566_7788 after 3 busy cycles -> mmioOpm=0x0B, then response opm 0x53, same seq/addr, data[63:0]=0x1122334455667788.
- Store: opm 0x00A2, data 0xDEADBEEF -> mmioOpm=0x12, mmioOutData=0xDEADBEEF; response opm 0x60, data 0.
- Fault: OK=11 with mmioExcIn=0x8003 -> response opm 0x70, data[63:0]=0x8003.
- Busy/ring contention: second MMIO request while in ISSUE forwarded unchanged; in RESP with occupied input slots response delayed until first empty slot.
- Async reset asserted in ISSUE -> all outputs 0 without a clock edge; with RBI_MMIO_TIMEOUT_EN, silent bus -> fault 0xF00D after 4095 cycles.
